writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 34 +++
 rtl/writeback_if.sv | 45 ++++
 rtl/writeback_arbiter.sv | 41 ++++
 rtl/writeback.sv | 81 ++++++++
 tb/tb_writeback.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/writeback_pkg.sv
// writeback_pkg: shared CPU parameters, pipeline types and write-back helpers.
//   cpu_parameters : xlen (data width), age_max (arbiter starvation limit)
//   interfaces_pkg : wb_state_e (RUN/FLUSH), wb_entry (rd, data, exception, target)
//   writeback_pkg  : unit indices and the fixed-priority pick helper
package cpu_parameters;
    localparam int xlen    = 32;
    localparam int age_max = 4;
endpackage

package interfaces_pkg;
    typedef enum logic {
        RUN,
        FLUSH
    } wb_state_e;

    typedef struct packed {
        logic [4:0]                     rd;
        logic [cpu_parameters::xlen-1:0] data;
        logic                           exception;
        logic [cpu_parameters::xlen-1:0] target;
    } wb_entry;
endpackage

package writeback_pkg;
    localparam int N_UNITS  = 3;
    localparam int UNIT_ALU = 0;
    localparam int UNIT_LSU = 1;
    localparam int UNIT_CSR = 2;

    // Fixed priority CSR > LSU > ALU, returns a one-hot (or zero) grant.
    function automatic logic [N_UNITS-1:0] prio_pick(input logic [N_UNITS-1:0] r);
        return r[UNIT_CSR] ? 3'b100 : r[UNIT_LSU] ? 3'b010 : r[UNIT_ALU] ? 3'b001 : 3'b000;
    endfunction
endpackage

// File: rtl/writeback_if.sv
// writeback_if: result offers from ALU/LSU/CSR and the write-back outputs.
//   offers   : <unit>_v, <unit>_rd, <unit>_result, csr_exception, csr_target
//   grants   : alu_ok, lsu_ok, csr_ok (combinational, offer consumed that cycle)
//   outputs  : rf_we, rf_rd, rf_wdata, instret_v, flush, pc_target (registered)
//   master   : the pipeline side driving offers; slave : the writeback stage
interface writeback_if #(
    parameter int XLEN = cpu_parameters::xlen
);
    logic            alu_v;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            lsu_v;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_result;
    logic            csr_v;
    logic [4:0]      csr_rd;
    logic [XLEN-1:0] csr_result;
    logic            csr_exception;
    logic [XLEN-1:0] csr_target;
    logic            alu_ok;
    logic            lsu_ok;
    logic            csr_ok;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            instret_v;
    logic            flush;
    logic [XLEN-1:0] pc_target;

    modport master (
        output alu_v, alu_rd, alu_result,
        output lsu_v, lsu_rd, lsu_result,
        output csr_v, csr_rd, csr_result, csr_exception, csr_target,
        input  alu_ok, lsu_ok, csr_ok,
        input  rf_we, rf_rd, rf_wdata, instret_v, flush, pc_target
    );

    modport slave (
        input  alu_v, alu_rd, alu_result,
        input  lsu_v, lsu_rd, lsu_result,
        input  csr_v, csr_rd, csr_result, csr_exception, csr_target,
        output alu_ok, lsu_ok, csr_ok,
        output rf_we, rf_rd, rf_wdata, instret_v, flush, pc_target
    );
endinterface

// File: rtl/writeback_arbiter.sv
// wb_arbiter: age-based priority arbiter for the three result producers.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : {csr, lsu, alu} offer valid
//   urgent     : CSR exception pending, wins unconditionally
//   block      : suppress all grants and clear ages (flush cycle)
//   gnt        : one-hot combinational grant, zero while in reset
module wb_arbiter
    import writeback_pkg::*;
#(
    parameter int AGE_MAX = cpu_parameters::age_max
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_UNITS-1:0] req,
    input  logic               urgent,
    input  logic               block,
    output logic [N_UNITS-1:0] gnt
);
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AMAX = AW'(AGE_MAX);

    logic [N_UNITS-1:0][AW-1:0] age_q, age_d;
    logic [N_UNITS-1:0]         aged;

    always_comb begin
        for (int i = 0; i < N_UNITS; i++) aged[i] = req[i] && age_q[i] == AMAX;
        // Starved requesters override default priority; among several starved
        // ones the default order breaks the tie.
        gnt = (!rst_n || block) ? '0 :
              urgent            ? 3'b100 :
              (|aged)           ? prio_pick(aged) : prio_pick(req);
        for (int i = 0; i < N_UNITS; i++)
            age_d[i] = (block || !req[i] || gnt[i]) ? '0 :
                       (age_q[i] == AMAX)           ? age_q[i] : age_q[i] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end
endmodule

// File: rtl/writeback.sv
// writeback: arbitrates ALU/LSU/CSR results into the register file, pulses
// retire, and turns a granted CSR exception into a one-cycle flush/redirect.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : writeback_if.slave carrying offers, grants and outputs
module writeback
    import writeback_pkg::*;
    import interfaces_pkg::*;
#(
    parameter int XLEN    = cpu_parameters::xlen,
    parameter int AGE_MAX = cpu_parameters::age_max
) (
    input  logic     clk,
    input  logic     rst_n,
    writeback_if.slave wb
);
    wb_state_e          state_q, state_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
    logic               instret_q, instret_d;
    logic [XLEN-1:0]    pc_target_q, pc_target_d;
    logic [N_UNITS-1:0] req, gnt;
    logic               any;
    wb_entry            sel;

    assign req = {wb.csr_v | wb.csr_exception, wb.lsu_v, wb.alu_v};

    wb_arbiter #(.AGE_MAX(AGE_MAX)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .urgent (wb.csr_exception),
        .block  (state_q == FLUSH),
        .gnt    (gnt)
    );

    always_comb begin
        any = |gnt;
        sel = gnt[UNIT_CSR] ? wb_entry'{rd: wb.csr_rd, data: wb.csr_result,
                                        exception: wb.csr_exception, target: wb.csr_target} :
              gnt[UNIT_LSU] ? wb_entry'{rd: wb.lsu_rd, data: wb.lsu_result,
                                        exception: 1'b0, target: '0} :
                              wb_entry'{rd: wb.alu_rd, data: wb.alu_result,
                                        exception: 1'b0, target: '0};
        // FLUSH never grants, so it always falls back to RUN after one cycle.
        state_d     = (any && sel.exception) ? FLUSH : RUN;
        instret_d   = any && !sel.exception;
        rf_we_d     = instret_d && sel.rd != 5'd0;
        rf_rd_d     = instret_d ? sel.rd : rf_rd_q;
        rf_wdata_d  = instret_d ? sel.data : rf_wdata_q;
        pc_target_d = (state_d == FLUSH) ? sel.target : pc_target_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            instret_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            instret_q   <= instret_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign wb.alu_ok    = gnt[UNIT_ALU];
    assign wb.lsu_ok    = gnt[UNIT_LSU];
    assign wb.csr_ok    = gnt[UNIT_CSR];
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_wdata  = rf_wdata_q;
    assign wb.instret_v = instret_q;
    assign wb.flush     = state_q == FLUSH;
    assign wb.pc_target = pc_target_q;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: table-driven and hand-sequenced checks of the writeback stage.
module tb_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_if #(.XLEN(32)) wb ();
    writeback #(.XLEN(32), .AGE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .wb(wb));

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        instret;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ares;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lres;
        logic        cv;
        logic        cexc;
        logic [4:0]  crd;
        logic [31:0] cres;
        logic [31:0] ctgt;
        logic [2:0]  gnt;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pc = '0;
    vec_t vec[9];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        wb.alu_v = 0; wb.alu_rd = 0; wb.alu_result = 0;
        wb.lsu_v = 0; wb.lsu_rd = 0; wb.lsu_result = 0;
        wb.csr_v = 0; wb.csr_rd = 0; wb.csr_result = 0;
        wb.csr_exception = 0; wb.csr_target = 0;
    endtask

    function automatic exp_t idle_exp();
        return '{1'b0, m_rd, m_data, 1'b0, 1'b0, m_pc};
    endfunction

    // One clock: check grants mid-cycle, queue the expected write-back, then
    // compare the registered outputs just after the edge.
    task automatic cyc(input string n, input logic [2:0] g, input exp_t e);
        exp_t x;
        @(negedge clk);
        chk({n, ".grant"}, {29'd0, wb.csr_ok, wb.lsu_ok, wb.alu_ok}, {29'd0, g});
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({n, ".rf_we"}, {31'd0, wb.rf_we}, {31'd0, x.we});
        chk({n, ".rf_rd"}, {27'd0, wb.rf_rd}, {27'd0, x.rd});
        chk({n, ".rf_wdata"}, wb.rf_wdata, x.data);
        chk({n, ".instret_v"}, {31'd0, wb.instret_v}, {31'd0, x.instret});
        chk({n, ".flush"}, {31'd0, wb.flush}, {31'd0, x.flush});
        chk({n, ".pc_target"}, wb.pc_target, x.pc);
        m_rd = x.rd;
        m_data = x.data;
        m_pc = x.pc;
    endtask

    task automatic chk_zero(input string n);
        chk({n, ".rf_we"}, {31'd0, wb.rf_we}, 32'd0);
        chk({n, ".rf_rd"}, {27'd0, wb.rf_rd}, 32'd0);
        chk({n, ".rf_wdata"}, wb.rf_wdata, 32'd0);
        chk({n, ".instret_v"}, {31'd0, wb.instret_v}, 32'd0);
        chk({n, ".flush"}, {31'd0, wb.flush}, 32'd0);
        chk({n, ".pc_target"}, wb.pc_target, 32'd0);
        chk({n, ".grant"}, {29'd0, wb.csr_ok, wb.lsu_ok, wb.alu_ok}, 32'd0);
    endtask

    initial begin
        vec[0] = '{1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001,
                   '{1, 5, 32'h1234, 1, 0, 32'h0}};
        vec[1] = '{0, 0, 0, 1, 7, 32'hdeadbeef, 0, 0, 0, 0, 0, 3'b010,
                   '{1, 7, 32'hdeadbeef, 1, 0, 32'h0}};
        vec[2] = '{0, 0, 0, 0, 0, 0, 1, 0, 3, 32'hcafe, 0, 3'b100,
                   '{1, 3, 32'hcafe, 1, 0, 32'h0}};
        vec[3] = '{1, 1, 32'haaaa, 1, 2, 32'hbbbb, 0, 0, 0, 0, 0, 3'b010,
                   '{1, 2, 32'hbbbb, 1, 0, 32'h0}};
        vec[4] = '{1, 0, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001,
                   '{0, 0, 32'h5555, 1, 0, 32'h0}};
        vec[5] = '{1, 6, 32'h66, 0, 0, 0, 0, 1, 4, 32'h77, 32'h80000040, 3'b100,
                   '{0, 0, 32'h5555, 0, 1, 32'h80000040}};
        vec[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000,
                   '{0, 0, 32'h5555, 0, 0, 32'h80000040}};
        vec[7] = '{0, 0, 0, 1, 8, 32'h88, 1, 0, 9, 32'h99, 0, 3'b100,
                   '{1, 9, 32'h99, 1, 0, 32'h80000040}};
        vec[8] = '{1, 10, 32'ha, 1, 11, 32'hb, 0, 1, 12, 32'hc, 32'h100, 3'b100,
                   '{0, 9, 32'h99, 0, 1, 32'h100}};

        clear_inputs();
        #2;
        wb.alu_v = 1;
        #1;
        chk_zero("reset");
        clear_inputs();
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            wb.alu_v = vec[i].av; wb.alu_rd = vec[i].ard; wb.alu_result = vec[i].ares;
            wb.lsu_v = vec[i].lv; wb.lsu_rd = vec[i].lrd; wb.lsu_result = vec[i].lres;
            wb.csr_v = vec[i].cv; wb.csr_exception = vec[i].cexc;
            wb.csr_rd = vec[i].crd; wb.csr_result = vec[i].cres; wb.csr_target = vec[i].ctgt;
            cyc($sformatf("vec%0d", i), vec[i].gnt, vec[i].e);
            clear_inputs();
            cyc($sformatf("vec%0d_idle", i), 3'b000, idle_exp());
        end

        // All three offer at once: CSR, then LSU, then ALU.
        wb.alu_v = 1; wb.alu_rd = 1; wb.alu_result = 32'h11;
        wb.lsu_v = 1; wb.lsu_rd = 2; wb.lsu_result = 32'h22;
        wb.csr_v = 1; wb.csr_rd = 3; wb.csr_result = 32'h33;
        cyc("order_csr", 3'b100, '{1, 3, 32'h33, 1, 0, m_pc});
        wb.csr_v = 0;
        cyc("order_lsu", 3'b010, '{1, 2, 32'h22, 1, 0, m_pc});
        wb.lsu_v = 0;
        cyc("order_alu", 3'b001, '{1, 1, 32'h11, 1, 0, m_pc});
        clear_inputs();
        cyc("order_idle", 3'b000, idle_exp());

        // Starvation: ALU promoted on its fifth waiting cycle.
        wb.lsu_v = 1; wb.lsu_rd = 13; wb.lsu_result = 32'hd0;
        wb.alu_v = 1; wb.alu_rd = 14; wb.alu_result = 32'he0;
        for (int k = 1; k <= 4; k++)
            cyc($sformatf("age_lsu%0d", k), 3'b010, '{1, 13, 32'hd0, 1, 0, m_pc});
        cyc("age_alu", 3'b001, '{1, 14, 32'he0, 1, 0, m_pc});
        wb.alu_v = 0;
        cyc("age_lsu_after", 3'b010, '{1, 13, 32'hd0, 1, 0, m_pc});
        clear_inputs();
        cyc("age_idle", 3'b000, idle_exp());

        // Exception beats a waiting ALU; ALU blocked during flush, then retires.
        wb.csr_exception = 1; wb.csr_target = 32'h80000040;
        wb.alu_v = 1; wb.alu_rd = 9; wb.alu_result = 32'h9999;
        cyc("exc_grant", 3'b100, '{0, m_rd, m_data, 0, 1, 32'h80000040});
        wb.csr_exception = 0;
        cyc("exc_flush", 3'b000, '{0, m_rd, m_data, 0, 0, 32'h80000040});
        cyc("exc_resume", 3'b001, '{1, 9, 32'h9999, 1, 0, 32'h80000040});
        clear_inputs();
        cyc("exc_idle", 3'b000, idle_exp());

        // Reset pulsed during the flush cycle aborts it.
        wb.csr_exception = 1; wb.csr_target = 32'h20000000;
        cyc("rst_exc", 3'b100, '{0, m_rd, m_data, 0, 1, 32'h20000000});
        clear_inputs();
        wb.alu_v = 1; wb.alu_rd = 15; wb.alu_result = 32'hf;
        #1 rst_n = 0;
        #1;
        chk_zero("rst_mid_flush");
        wb.alu_v = 0;
        #1 rst_n = 1;
        m_rd = 0; m_data = 0; m_pc = 0;
        cyc("rst_after1", 3'b000, idle_exp());
        cyc("rst_after2", 3'b000, idle_exp());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
